// File: rtl/ctrl_multiciclo_pkg.sv
// Shared state codes, opcode values and datapath select encodings for the multicycle
// RV32I controller.
package ctrl_multiciclo_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecI    = 4'd3,
        StAluWb    = 4'd4,
        StMemAddr  = 4'd5,
        StMemRead  = 4'd6,
        StMemWb    = 4'd7,
        StMemWrite = 4'd8,
        StBranch   = 4'd9,
        StTrap     = 4'd10
    } state_e;

    localparam logic [6:0] OpcRType  = 7'b0110011;
    localparam logic [6:0] OpcIType  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [1:0] AluAPc    = 2'b00;
    localparam logic [1:0] AluARs1   = 2'b01;
    localparam logic [1:0] AluAOldPc = 2'b10;

    localparam logic [1:0] AluBRs2    = 2'b00;
    localparam logic [1:0] AluBFour   = 2'b01;
    localparam logic [1:0] AluBImm    = 2'b10;
    localparam logic [1:0] AluBImmSh1 = 2'b11;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

endpackage

// File: rtl/ctrl_multiciclo_mem_wait_timer.sv
// Counts consecutive cycles a memory request waits for ready; flags expiry so the
// controller can trap instead of stalling forever.
module ctrl_multiciclo_mem_wait_timer #(
    parameter int unsigned Timeout = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic ready_i,
    output logic expired_o
);

    localparam int unsigned Width = $clog2(Timeout + 1);

    logic [Width-1:0] count_q, count_d;
    logic             waiting;

    assign waiting = req_i & ~ready_i;

    // Saturates at Timeout; any cycle that is not a stalled request clears the count.
    always_comb begin
        count_d = '0;
        if (waiting) begin
            count_d = (count_q == Width'(Timeout)) ? count_q : count_q + Width'(1);
        end
    end

    assign expired_o = waiting && (count_d == Width'(Timeout));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ctrl_multiciclo.sv
// Multicycle RV32I control FSM: sequences a shared-memory, single-ALU datapath and traps
// the core when a memory request waits too long.
import ctrl_multiciclo_pkg::*;

module ctrl_multiciclo #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       pcsource_o,
    output logic       iord_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       memtoreg_o,
    output logic       regwrite_o,
    output logic [1:0] alusrc_a_o,
    output logic [1:0] alusrc_b_o,
    output logic [1:0] aluop_o,
    output logic       instret_o,
    output logic       illegal_o,
    output logic       halted_o,
    output logic [3:0] state_o
);

    state_e state_q, state_d;
    logic   mem_timeout;

    ctrl_multiciclo_mem_wait_timer #(
        .Timeout(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (mem_req_o),
        .ready_i  (mem_ready_i),
        .expired_o(mem_timeout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

    always_comb begin
        state_d         = state_q;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pcsource_o      = 1'b0;
        iord_o          = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        memtoreg_o      = 1'b0;
        regwrite_o      = 1'b0;
        alusrc_a_o      = AluAPc;
        alusrc_b_o      = AluBRs2;
        aluop_o         = AluOpAdd;
        instret_o       = 1'b0;
        illegal_o       = 1'b0;
        halted_o        = 1'b0;

        // Outputs are gated by reset so an in-flight request drops without waiting for a clock.
        if (rst_ni) begin
            case (state_q)
                StFetch: begin
                    if (run_i) begin
                        mem_req_o  = 1'b1;
                        alusrc_a_o = AluAPc;
                        alusrc_b_o = AluBFour;
                        aluop_o    = AluOpAdd;
                        if (mem_ready_i) begin
                            ir_write_o = 1'b1;
                            pc_write_o = 1'b1;
                            state_d    = StDecode;
                        end
                    end
                end
                StDecode: begin
                    alusrc_a_o = AluAOldPc;
                    alusrc_b_o = AluBImmSh1;
                    aluop_o    = AluOpAdd;
                    case (opcode_i)
                        OpcRType:           state_d = StExecR;
                        OpcIType:           state_d = StExecI;
                        OpcLoad, OpcStore:  state_d = StMemAddr;
                        OpcBranch:          state_d = StBranch;
                        default: begin
                            illegal_o = 1'b1;
                            state_d   = StFetch;
                        end
                    endcase
                end
                StExecR: begin
                    alusrc_a_o = AluARs1;
                    alusrc_b_o = AluBRs2;
                    aluop_o    = AluOpFunct;
                    state_d    = StAluWb;
                end
                StExecI: begin
                    alusrc_a_o = AluARs1;
                    alusrc_b_o = AluBImm;
                    aluop_o    = AluOpFunct;
                    state_d    = StAluWb;
                end
                StAluWb: begin
                    regwrite_o = 1'b1;
                    instret_o  = 1'b1;
                    state_d    = StFetch;
                end
                StMemAddr: begin
                    alusrc_a_o = AluARs1;
                    alusrc_b_o = AluBImm;
                    aluop_o    = AluOpAdd;
                    state_d    = (opcode_i == OpcLoad) ? StMemRead : StMemWrite;
                end
                StMemRead: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                    if (mem_ready_i) begin
                        state_d = StMemWb;
                    end
                end
                StMemWb: begin
                    regwrite_o = 1'b1;
                    memtoreg_o = 1'b1;
                    instret_o  = 1'b1;
                    state_d    = StFetch;
                end
                StMemWrite: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    iord_o    = 1'b1;
                    if (mem_ready_i) begin
                        instret_o = 1'b1;
                        state_d   = StFetch;
                    end
                end
                StBranch: begin
                    alusrc_a_o      = AluARs1;
                    alusrc_b_o      = AluBRs2;
                    aluop_o         = AluOpSub;
                    pc_write_cond_o = 1'b1;
                    pcsource_o      = 1'b1;
                    instret_o       = 1'b1;
                    state_d         = StFetch;
                end
                StTrap: begin
                    halted_o = 1'b1;
                end
                default: begin
                    state_d = StTrap;
                end
            endcase

            // Expiry implies ready is low, so no write was issued this cycle.
            if (mem_timeout) begin
                state_d = StTrap;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Directed bench for ctrl_multiciclo: stimulus pushes hand-computed per-cycle output
// vectors into a scoreboard queue; a negedge monitor pops and compares.
module tb_ctrl_multiciclo;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       run_i;
    logic [6:0] opcode_i;
    logic       mem_ready_i;
    logic       ir_write_o, pc_write_o, pc_write_cond_o, pcsource_o, iord_o;
    logic       mem_req_o, mem_we_o, memtoreg_o, regwrite_o;
    logic [1:0] alusrc_a_o, alusrc_b_o, aluop_o;
    logic       instret_o, illegal_o, halted_o;
    logic [3:0] state_o;

    ctrl_multiciclo #(
        .MEM_TIMEOUT(15)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .run_i          (run_i),
        .opcode_i       (opcode_i),
        .mem_ready_i    (mem_ready_i),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .pc_write_cond_o(pc_write_cond_o),
        .pcsource_o     (pcsource_o),
        .iord_o         (iord_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .memtoreg_o     (memtoreg_o),
        .regwrite_o     (regwrite_o),
        .alusrc_a_o     (alusrc_a_o),
        .alusrc_b_o     (alusrc_b_o),
        .aluop_o        (aluop_o),
        .instret_o      (instret_o),
        .illegal_o      (illegal_o),
        .halted_o       (halted_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'h7F;

    localparam logic [21:0] F_IRW   = 22'd1 << 0;
    localparam logic [21:0] F_PCW   = 22'd1 << 1;
    localparam logic [21:0] F_PWC   = 22'd1 << 2;
    localparam logic [21:0] F_PCSRC = 22'd1 << 3;
    localparam logic [21:0] F_IORD  = 22'd1 << 4;
    localparam logic [21:0] F_REQ   = 22'd1 << 5;
    localparam logic [21:0] F_WE    = 22'd1 << 6;
    localparam logic [21:0] F_MTR   = 22'd1 << 7;
    localparam logic [21:0] F_REGW  = 22'd1 << 8;
    localparam logic [21:0] F_RET   = 22'd1 << 15;
    localparam logic [21:0] F_ILL   = 22'd1 << 16;
    localparam logic [21:0] F_HALT  = 22'd1 << 17;

    logic [21:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    wire [21:0] got = {state_o, halted_o, illegal_o, instret_o, aluop_o, alusrc_b_o, alusrc_a_o,
                       regwrite_o, memtoreg_o, mem_we_o, mem_req_o, iord_o, pcsource_o,
                       pc_write_cond_o, pc_write_o, ir_write_o};

    function automatic logic [21:0] mk(input logic [3:0] st, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic [21:0] f);
        return f | {st, 3'b000, op, b, a, 9'b0};
    endfunction

    // Drive one cycle of inputs just after the edge and queue the outputs expected in it.
    task automatic step(input logic rst, input logic run, input logic [6:0] opc,
                        input logic rdy, input logic [21:0] e, input string n);
        @(posedge clk);
        #1;
        rst_ni      = rst;
        run_i       = run;
        opcode_i    = opc;
        mem_ready_i = rdy;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    logic [21:0] mon_e;
    string       mon_n;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (got !== mon_e) begin
                failures++;
                $display("FAIL %s: got %h expected %h (state %0d)", mon_n, got, mon_e, state_o);
            end
        end
    end

    initial begin
        rst_ni      = 1'b0;
        run_i       = 1'b1;
        opcode_i    = 7'd0;
        mem_ready_i = 1'b1;

        step(0, 1, OP_R, 1, 22'd0, "reset_outputs");
        step(0, 1, OP_R, 1, 22'd0, "reset_hold");

        // R-type add, zero-wait memory
        step(1, 1, OP_R, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "r_fetch");
        step(1, 1, OP_R, 1, mk(4'd1, 2'b10, 2'b11, 2'b00, 22'd0), "r_decode");
        step(1, 1, OP_R, 1, mk(4'd2, 2'b01, 2'b00, 2'b10, 22'd0), "r_exec");
        step(1, 1, OP_R, 1, mk(4'd4, 2'b00, 2'b00, 2'b00, F_REGW | F_RET), "r_wb");

        // Load with two wait cycles in MEM_READ
        step(1, 1, OP_LD, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "ld_fetch");
        step(1, 1, OP_LD, 0, mk(4'd1, 2'b10, 2'b11, 2'b00, 22'd0), "ld_decode");
        step(1, 1, OP_LD, 0, mk(4'd5, 2'b01, 2'b10, 2'b00, 22'd0), "ld_addr");
        step(1, 1, OP_LD, 0, mk(4'd6, 2'b00, 2'b00, 2'b00, F_REQ | F_IORD), "ld_wait1");
        step(1, 1, OP_LD, 0, mk(4'd6, 2'b00, 2'b00, 2'b00, F_REQ | F_IORD), "ld_wait2");
        step(1, 1, OP_LD, 1, mk(4'd6, 2'b00, 2'b00, 2'b00, F_REQ | F_IORD), "ld_ready");
        step(1, 1, OP_LD, 0, mk(4'd7, 2'b00, 2'b00, 2'b00, F_REGW | F_MTR | F_RET), "ld_wb");

        // Branch
        step(1, 1, OP_BR, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "br_fetch");
        step(1, 1, OP_BR, 1, mk(4'd1, 2'b10, 2'b11, 2'b00, 22'd0), "br_decode");
        step(1, 1, OP_BR, 1, mk(4'd9, 2'b01, 2'b00, 2'b01, F_PWC | F_PCSRC | F_RET), "br_exec");

        // Illegal opcode
        step(1, 1, OP_BAD, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "ill_fetch");
        step(1, 1, OP_BAD, 1, mk(4'd1, 2'b10, 2'b11, 2'b00, F_ILL), "ill_decode");

        // I-type
        step(1, 1, OP_I, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "i_fetch");
        step(1, 1, OP_I, 1, mk(4'd1, 2'b10, 2'b11, 2'b00, 22'd0), "i_decode");
        step(1, 1, OP_I, 1, mk(4'd3, 2'b01, 2'b10, 2'b10, 22'd0), "i_exec");
        step(1, 1, OP_I, 1, mk(4'd4, 2'b00, 2'b00, 2'b00, F_REGW | F_RET), "i_wb");

        // Store, zero-wait
        step(1, 1, OP_ST, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "st_fetch");
        step(1, 1, OP_ST, 1, mk(4'd1, 2'b10, 2'b11, 2'b00, 22'd0), "st_decode");
        step(1, 1, OP_ST, 1, mk(4'd5, 2'b01, 2'b10, 2'b00, 22'd0), "st_addr");
        step(1, 1, OP_ST, 1, mk(4'd8, 2'b00, 2'b00, 2'b00, F_REQ | F_WE | F_IORD | F_RET),
             "st_write");

        // Idle: run low, ready without request ignored
        step(1, 0, OP_R, 1, 22'd0, "idle_ready_ignored");
        step(1, 0, OP_R, 0, 22'd0, "idle_hold");

        // Reset asserted mid-store
        step(1, 1, OP_ST, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "rs_fetch");
        step(1, 1, OP_ST, 0, mk(4'd1, 2'b10, 2'b11, 2'b00, 22'd0), "rs_decode");
        step(1, 1, OP_ST, 0, mk(4'd5, 2'b01, 2'b10, 2'b00, 22'd0), "rs_addr");
        step(1, 1, OP_ST, 0, mk(4'd8, 2'b00, 2'b00, 2'b00, F_REQ | F_WE | F_IORD), "rs_write");
        step(0, 1, OP_ST, 0, 22'd0, "rs_reset_drop");
        step(1, 0, OP_ST, 1, 22'd0, "rs_release_idle");
        step(1, 0, OP_ST, 0, 22'd0, "rs_idle2");

        // Store with ready stuck low: 15 wait cycles then TRAP
        step(1, 1, OP_ST, 1, mk(4'd0, 2'b00, 2'b01, 2'b00, F_REQ | F_IRW | F_PCW), "to_fetch");
        step(1, 1, OP_ST, 0, mk(4'd1, 2'b10, 2'b11, 2'b00, 22'd0), "to_decode");
        step(1, 1, OP_ST, 1, mk(4'd5, 2'b01, 2'b10, 2'b00, 22'd0), "to_addr");
        for (int i = 0; i < 15; i++) begin
            step(1, 1, OP_ST, 0, mk(4'd8, 2'b00, 2'b00, 2'b00, F_REQ | F_WE | F_IORD), "to_wait");
        end
        for (int i = 0; i < 4; i++) begin
            step(1, i[0], OP_ST, 1, mk(4'd10, 2'b00, 2'b00, 2'b00, F_HALT), "trap_hold");
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
